// File: rtl/door_pkg.sv
// Shared types and sizing for the door-lock timing controller.
package door_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned FAIL_W = 2;

    typedef enum logic [1:0] {
        StLocked   = 2'd0,
        StUnlocked = 2'd1,
        StLockout  = 2'd2
    } door_state_e;

    // Prescaler width for a terminal count of clk_hz-1; never narrower than one bit.
    function automatic int unsigned presc_width(input int unsigned clk_hz);
        return (clk_hz > 1) ? $clog2(clk_hz) : 1;
    endfunction

endpackage

// File: rtl/door_timer_ctrl_if.sv
// Keypad-compare inputs and actuator/display outputs of the door timer.
interface door_timer_ctrl_if;
    import door_pkg::*;

    logic              pass_ok;
    logic              pass_fail;
    logic              lock_now;
    logic              door_open;
    logic              lockout;
    logic [FAIL_W-1:0] fail_cnt;
    logic [SEC_W-1:0]  sec_left;
    logic              tick_1hz;
    logic              blink;

    // Master drives the compare pulses and observes the timer.
    modport master (
        output pass_ok, pass_fail, lock_now,
        input  door_open, lockout, fail_cnt, sec_left, tick_1hz, blink
    );

    // Slave is the timer itself.
    modport slave (
        input  pass_ok, pass_fail, lock_now,
        output door_open, lockout, fail_cnt, sec_left, tick_1hz, blink
    );

endinterface

// File: rtl/door_tick_gen.sv
// Free-running 1 Hz prescaler: single-cycle enable tick plus a blink phase flag.
module door_tick_gen
    import door_pkg::*;
#(
    parameter int unsigned CLK_HZ = 125000000
) (
    input  logic clk_ht,
    input  logic reset,
    input  logic clr_i,
    input  logic blink_en_i,
    output logic tick_1hz_o,
    output logic blink_phase_o
);

    localparam int unsigned     CntW    = presc_width(CLK_HZ);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_HZ - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLK_HZ / 2);

    logic [CntW-1:0] cnt_d, cnt_q;
    logic            tick_d, tick_q;
    logic            blink_d, blink_q;

    // Next count, tick and blink; a clear also drops a tick that would land in the first cycle.
    always_comb begin
        cnt_d   = cnt_q + CntW'(1);
        tick_d  = 1'b0;
        blink_d = 1'b0;
        if (clr_i || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end
        if (!clr_i && (cnt_q == CntLast)) begin
            tick_d = 1'b1;
        end
        // Registered from cnt_d so the flag lines up with the count it describes.
        blink_d = blink_en_i && (cnt_d < CntHalf);
    end

    // Prescaler state.
    always_ff @(posedge clk_ht or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
        end
    end

    assign tick_1hz_o    = tick_q;
    assign blink_phase_o = blink_q;

endmodule

// File: rtl/door_timer_ctrl.sv
// Door-lock timing controller: unlock hold window, wrong-attempt counter and timed lockout.
module door_timer_ctrl
    import door_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 125000000,
    parameter int unsigned UNLOCK_S  = 5,
    parameter int unsigned LOCKOUT_S = 30,
    parameter int unsigned MAX_FAIL  = 3
) (
    input  logic              clk_ht,
    input  logic              reset,
    door_timer_ctrl_if.slave  bus
);

    localparam logic [SEC_W-1:0]  UnlockSec  = SEC_W'(UNLOCK_S);
    localparam logic [SEC_W-1:0]  LockoutSec = SEC_W'(LOCKOUT_S);
    localparam logic [FAIL_W-1:0] MaxFail    = FAIL_W'(MAX_FAIL);

    door_state_e       state_d, state_q;
    logic [SEC_W-1:0]  sec_d, sec_q;
    logic [FAIL_W-1:0] fail_d, fail_q;
    logic              door_open_d, door_open_q;
    logic              lockout_d, lockout_q;
    logic              presc_clr;
    logic              tick;
    logic              blink;

    door_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk_ht        (clk_ht),
        .reset         (reset),
        .clr_i         (presc_clr),
        .blink_en_i    (state_d != StLocked),
        .tick_1hz_o    (tick),
        .blink_phase_o (blink)
    );

    // Next-state logic; the prescaler is cleared on every entry or extension of a timed state.
    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        fail_d    = fail_q;
        presc_clr = 1'b0;
        unique case (state_q)
            StLocked: begin
                if (bus.pass_fail) begin
                    if (fail_q + FAIL_W'(1) == MaxFail) begin
                        state_d   = StLockout;
                        sec_d     = LockoutSec;
                        fail_d    = MaxFail;
                        presc_clr = 1'b1;
                    end else begin
                        fail_d = fail_q + FAIL_W'(1);
                    end
                end else if (bus.pass_ok) begin
                    state_d   = StUnlocked;
                    sec_d     = UnlockSec;
                    fail_d    = '0;
                    presc_clr = 1'b1;
                end
            end
            StUnlocked: begin
                if (bus.lock_now) begin
                    state_d = StLocked;
                    sec_d   = '0;
                end else if (bus.pass_ok) begin
                    sec_d     = UnlockSec;
                    presc_clr = 1'b1;
                end else if (tick) begin
                    if (sec_q == SEC_W'(1)) begin
                        state_d = StLocked;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q - SEC_W'(1);
                    end
                end
            end
            StLockout: begin
                if (tick) begin
                    if (sec_q == SEC_W'(1)) begin
                        state_d = StLocked;
                        sec_d   = '0;
                        fail_d  = '0;
                    end else begin
                        sec_d = sec_q - SEC_W'(1);
                    end
                end
            end
            default: begin
                state_d = StLocked;
                sec_d   = '0;
            end
        endcase
        door_open_d = (state_d == StUnlocked);
        lockout_d   = (state_d == StLockout);
    end

    // FSM, counters and registered state outputs.
    always_ff @(posedge clk_ht or negedge reset) begin
        if (!reset) begin
            state_q     <= StLocked;
            sec_q       <= '0;
            fail_q      <= '0;
            door_open_q <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            fail_q      <= fail_d;
            door_open_q <= door_open_d;
            lockout_q   <= lockout_d;
        end
    end

    // A timed state always holds a non-zero count, so a tick can never decrement 0.
    a_sec_nonzero: assert property (@(posedge clk_ht) disable iff (!reset)
        (state_q != StLocked) |-> (sec_q != '0));

    assign bus.door_open = door_open_q;
    assign bus.lockout   = lockout_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.sec_left  = sec_q;
    assign bus.tick_1hz  = tick;
    assign bus.blink     = blink;

endmodule

// File: tb/tb_door_timer_ctrl.sv
// Directed bench for door_timer_ctrl with CLK_HZ=10, UNLOCK_S=3, LOCKOUT_S=4, MAX_FAIL=3.
module tb_door_timer_ctrl;

    logic clk_ht = 1'b0;
    logic reset  = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    door_timer_ctrl_if bus ();

    door_timer_ctrl #(
        .CLK_HZ    (10),
        .UNLOCK_S  (3),
        .LOCKOUT_S (4),
        .MAX_FAIL  (3)
    ) dut (
        .clk_ht (clk_ht),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_ht = ~clk_ht;

    typedef struct {
        logic       po;
        logic       pf;
        logic       ln;
        logic       door;
        logic       lko;
        logic [1:0] fail;
        logic [5:0] sec;
        logic       blk;
        string      name;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic po, input logic pf, input logic ln,
                                input logic door, input logic lko, input logic [1:0] fail,
                                input logic [5:0] sec, input logic blk, input string name);
        vec_t v;
        v.po = po; v.pf = pf; v.ln = ln;
        v.door = door; v.lko = lko; v.fail = fail; v.sec = sec; v.blk = blk;
        v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int door, input int lko, input int fail,
                           input int sec, input int blk);
        chk({name, ".door_open"}, int'(bus.door_open), door);
        chk({name, ".lockout"},   int'(bus.lockout),   lko);
        chk({name, ".fail_cnt"},  int'(bus.fail_cnt),  fail);
        chk({name, ".sec_left"},  int'(bus.sec_left),  sec);
        chk({name, ".blink"},     int'(bus.blink),     blk);
    endtask

    task automatic step();
        @(posedge clk_ht);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive the pulses for exactly one clock edge.
    task automatic pulse(input logic po, input logic pf, input logic ln);
        bus.pass_ok   = po;
        bus.pass_fail = pf;
        bus.lock_now  = ln;
        step();
        bus.pass_ok   = 1'b0;
        bus.pass_fail = 1'b0;
        bus.lock_now  = 1'b0;
    endtask

    initial begin
        int ticks;
        bus.pass_ok   = 1'b0;
        bus.pass_fail = 1'b0;
        bus.lock_now  = 1'b0;

        // Reset state, then idle in LOCKED with the free-running tick every 10 cycles.
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        chk("reset.tick", int'(bus.tick_1hz), 0);
        #10 reset = 1'b1;
        ticks = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            chk_all("idle", 0, 0, 0, 0, 0);
            chk($sformatf("idle.tick@%0d", k), int'(bus.tick_1hz), (k % 10 == 0) ? 1 : 0);
            if (bus.tick_1hz) ticks++;
        end
        chk("idle.tick_count", ticks, 5);

        // Failure counting into lockout; ignored inputs during lockout.
        vecs[0] = mk(0, 0, 1, 0, 0, 2'd0, 6'd0, 0, "locked_lock_now");
        vecs[1] = mk(0, 1, 0, 0, 0, 2'd1, 6'd0, 0, "fail1");
        vecs[2] = mk(0, 0, 0, 0, 0, 2'd1, 6'd0, 0, "fail1_hold");
        vecs[3] = mk(0, 1, 0, 0, 0, 2'd2, 6'd0, 0, "fail2");
        vecs[4] = mk(1, 1, 0, 0, 1, 2'd3, 6'd4, 1, "ok_and_fail_lockout");
        vecs[5] = mk(1, 0, 0, 0, 1, 2'd3, 6'd4, 1, "lockout_ok_ignored");
        vecs[6] = mk(0, 1, 0, 0, 1, 2'd3, 6'd4, 1, "lockout_fail_ignored");
        vecs[7] = mk(0, 0, 1, 0, 1, 2'd3, 6'd4, 1, "lockout_lock_now_ignored");
        for (int i = 0; i < 8; i++) begin
            pulse(vecs[i].po, vecs[i].pf, vecs[i].ln);
            chk_all(vecs[i].name, int'(vecs[i].door), int'(vecs[i].lko), int'(vecs[i].fail),
                    int'(vecs[i].sec), int'(vecs[i].blk));
        end

        // Lockout countdown: entry edge L0 was vecs[4]; now at L3.
        steps(7);
        chk_all("lockout_L10", 0, 1, 3, 4, 1);
        chk("lockout_L10.tick", int'(bus.tick_1hz), 1);
        step();
        chk_all("lockout_L11", 0, 1, 3, 3, 1);
        steps(29);
        chk_all("lockout_L40", 0, 1, 3, 1, 1);
        chk("lockout_L40.tick", int'(bus.tick_1hz), 1);
        step();
        chk_all("lockout_exit", 0, 0, 0, 0, 0);

        // Plain unlock window of three seconds.
        pulse(1, 0, 0);
        chk_all("unlock_U0", 1, 0, 0, 3, 1);
        step();
        chk("unlock_U1.tick", int'(bus.tick_1hz), 0);
        steps(4);
        chk_all("unlock_U5", 1, 0, 0, 3, 0);
        steps(5);
        chk_all("unlock_U10", 1, 0, 0, 3, 1);
        chk("unlock_U10.tick", int'(bus.tick_1hz), 1);
        step();
        chk_all("unlock_U11", 1, 0, 0, 2, 1);
        steps(10);
        chk_all("unlock_U21", 1, 0, 0, 1, 1);
        steps(9);
        chk_all("unlock_U30", 1, 0, 0, 1, 1);
        step();
        chk_all("unlock_exit", 0, 0, 0, 0, 0);

        // Extension on the last tick, fail ignored, then lock_now at sec_left=2.
        pulse(1, 0, 0);
        steps(30);
        chk_all("ext_V30", 1, 0, 0, 1, 1);
        chk("ext_V30.tick", int'(bus.tick_1hz), 1);
        pulse(1, 0, 0);
        chk_all("ext_reload", 1, 0, 0, 3, 1);
        chk("ext_reload.tick", int'(bus.tick_1hz), 0);
        pulse(0, 1, 0);
        chk_all("unlock_fail_ignored", 1, 0, 0, 3, 1);
        steps(9);
        chk("ext_V41.tick", int'(bus.tick_1hz), 1);
        chk("ext_V41.sec", int'(bus.sec_left), 3);
        step();
        chk("ext_V42.sec", int'(bus.sec_left), 2);
        pulse(0, 0, 1);
        chk_all("lock_now", 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a lockout.
        pulse(0, 1, 0);
        pulse(0, 1, 0);
        pulse(0, 1, 0);
        chk_all("lockout2_X0", 0, 1, 3, 4, 1);
        steps(5);
        #2 reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        chk("async_reset.tick", int'(bus.tick_1hz), 0);
        step();
        chk_all("held_reset", 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) chk_all("post_reset", 0, 0, 0, 0, 0);
            chk($sformatf("post_reset.tick@%0d", k), int'(bus.tick_1hz), (k == 10) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/door_timer_ctrl.md
Name: door_timer_ctrl

Overview:
Timing controller for the door-lock core. It owns a free-running prescaler that produces a single-cycle 1 Hz enable tick; it produces no derived clock. It uses that tick to sequence three things: the unlock hold window, the wrong-attempt counter, and the timed lockout. It sits between the keypad/password compare logic (pass_ok/pass_fail pulses) and the actuator/7-seg display (door_open, sec_left, blink).

Parameters:
CLK_HZ, 125000000, input clock frequency; prescaler terminal count is CLK_HZ-1; benches use a small value, e.g. 10.
UNLOCK_S, 5, seconds the door stays open after pass_ok; legal range 1..63.
LOCKOUT_S, 30, seconds of lockout after MAX_FAIL failures; legal range 1..63.
MAX_FAIL, 3, consecutive failures that trigger lockout; legal range 1..3.

Ports:
clk_ht  in  1  system clock, all logic on posedge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
pass_ok  in  1  one-cycle pulse: entered code correct.
pass_fail  in  1  one-cycle pulse: entered code wrong.
lock_now  in  1  level/pulse: force door closed immediately.
door_open  out  1  1 while in UNLOCKED.
lockout  out  1  1 while in LOCKOUT.
fail_cnt  out  2  consecutive failures so far.
sec_left  out  6  remaining whole seconds in the current timed state; 0 in LOCKED.
tick_1hz  out  1  one-cycle enable pulse, once per second.
blink  out  1  50% duty 1 Hz indicator in timed states.

Behaviour:
- Reset (reset=0, async): state=LOCKED, prescaler=0, sec_left=0, fail_cnt=0, and door_open, lockout, tick_1hz and blink all 0. Operation resumes on the first clk_ht edge after reset returns to 1.
- Prescaler: counts 0..CLK_HZ-1 and wraps. tick_1hz=1 exactly in the cycle after count==CLK_HZ-1 (registered). Counter width is $clog2(CLK_HZ); 27 bits at the default.
- The prescaler is cleared to 0 on every entry to UNLOCKED or LOCKOUT, so the first counted second is full length.
- blink = (prescaler < CLK_HZ/2) in UNLOCKED/LOCKOUT; 0 in LOCKED. Registered.
- All outputs are registered. State-visible outputs change one cycle after the causing input.
- States: LOCKED, UNLOCKED, LOCKOUT.
- LOCKED:
  - pass_fail: fail_cnt+1. If the new value == MAX_FAIL, go to LOCKOUT, load sec_left=LOCKOUT_S, fail_cnt stays at MAX_FAIL.
  - pass_ok (without pass_fail): go to UNLOCKED, sec_left=UNLOCK_S, fail_cnt=0.
  - pass_ok and pass_fail in the same cycle: pass_fail wins.
  - lock_now: no effect.
- UNLOCKED:
  - Each tick: sec_left-1. A tick with sec_left==1 goes to LOCKED with sec_left=0.
  - pass_ok: reload sec_left=UNLOCK_S and clear the prescaler (extend).
  - lock_now: go to LOCKED at once, sec_left=0. lock_now beats both tick and pass_ok.
  - pass_fail: ignored; fail_cnt unchanged.
- LOCKOUT:
  - pass_ok, pass_fail and lock_now are ignored.
  - Each tick: sec_left-1. A tick with sec_left==1 goes to LOCKED with sec_left=0 and fail_cnt=0.
- sec_left never underflows. A decrement at 0 is impossible by construction; assert it in simulation.
- Reset asserted mid-UNLOCKED or mid-LOCKOUT returns immediately to the reset values. No state is retained.
- Illegal state encoding recovers to LOCKED.

Decomposition:
- Package door_pkg: state enum (LOCKED, UNLOCKED, LOCKOUT), SEC_W=6, FAIL_W=2, and a function computing prescaler width from CLK_HZ.
- Sub-module door_tick_gen: prescaler with synchronous clear input, tick_1hz output and blink_phase output; same clk_ht/reset.
- The FSM, fail counter and seconds counter stay in door_timer_ctrl.

Test Plan:
(All scenarios use CLK_HZ=10, UNLOCK_S=3, LOCKOUT_S=4, MAX_FAIL=3.)
- Reset then idle 50 cycles -> state LOCKED, all outputs 0, tick_1hz pulses every 10 cycles (1 cycle wide), blink=0.
- pass_ok pulse -> next cycle door_open=1, sec_left=3. sec_left reads 2,1 on successive ticks. door_open=0 and sec_left=0 after the third tick (30 cycles after entry).
- pass_fail x3 in LOCKED -> fail_cnt 1,2, then lockout=1, sec_left=4. pass_ok during lockout is ignored. Exit after 40 cycles with fail_cnt=0.
- In UNLOCKED at sec_left=1, pulse pass_ok in the same cycle as tick -> sec_left reloads to 3, door stays open. Separately, lock_now at sec_left=2 -> door_open=0, sec_left=0 next cycle.
- pass_ok and pass_fail together in LOCKED with fail_cnt=2 -> lockout=1, door_open=0.
- Assert reset mid-LOCKOUT (asynchronous, between clock edges) -> outputs 0 immediately. Release -> LOCKED, fail_cnt=0, prescaler restarts from 0.
